// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, protection attributes, bridge FSM
// states, and the address/privilege decode used by every AXI4-Lite slave.
package axi4_lite;

  typedef enum logic [1:0] {
    AXI4_LITE_OKAY   = 2'b00,
    AXI4_LITE_EXOKAY = 2'b01,
    AXI4_LITE_SLVERR = 2'b10,
    AXI4_LITE_DECERR = 2'b11
  } axi4_lite_resp_t;

  typedef enum logic {
    AXI4_LITE_UNPRIVILEDGED_ACCESS = 1'b0,
    AXI4_LITE_PRIVILEDGED_ACCESS   = 1'b1
  } axi4_lite_priv_t;

  // Bit order matches AxPROT[2:0]: instruction, non-secure, privileged.
  typedef struct packed {
    logic            instruction;
    logic            nonsecure;
    axi4_lite_priv_t privilege;
  } axi4_lite_prot_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    RD_ISSUE,
    RD_WAIT,
    WR_RESP,
    RD_RESP
  } axi4_lite_mem_bridge_state_t;

  // Callers zero-extend their byte address to 64 bits; any bit above the
  // word window is an address outside this slave.
  function automatic axi4_lite_resp_t axi4_lite_decode_resp(
    input logic [63:0]     addr,
    input axi4_lite_prot_t prot,
    input int unsigned     mem_addr_width,
    input bit              require_priv
  );
    logic [63:0] above_window;
    above_window = addr >> (mem_addr_width + 2);
    if (above_window != '0) return AXI4_LITE_DECERR;
    if (require_priv && (prot.privilege == AXI4_LITE_UNPRIVILEDGED_ACCESS))
      return AXI4_LITE_SLVERR;
    return AXI4_LITE_OKAY;
  endfunction

endpackage

// File: rtl/axi4_lite_mem_bridge.sv
// AXI4-Lite slave bridging to a single-outstanding, word-addressed memory port.
// One FSM serialises reads and writes; errored accesses never reach memory.
module axi4_lite_mem_bridge
  import axi4_lite::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter bit REQUIRE_PRIV   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  axi4_lite_prot_t           awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output axi4_lite_resp_t           bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDR_WIDTH-1:0]     araddr,
  input  axi4_lite_prot_t           arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output axi4_lite_resp_t           rresp,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      mem_write,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  axi4_lite_mem_bridge_state_t state;
  logic            rr_write_first;
  logic            in_idle;
  logic            wr_cand;
  logic            rd_cand;
  logic            grant_wr;
  logic            grant_rd;
  axi4_lite_resp_t wr_resp;
  axi4_lite_resp_t rd_resp;

  // Readies are held low while reset is asserted so nothing is accepted
  // in a cycle whose state update is discarded.
  assign in_idle  = rst_n && (state == IDLE);
  assign wr_cand  = awvalid && wvalid;
  assign rd_cand  = arvalid;
  assign grant_rd = in_idle && rd_cand && (!wr_cand || !rr_write_first);
  assign grant_wr = in_idle && wr_cand && (!rd_cand || rr_write_first);

  assign awready = grant_wr;
  assign wready  = grant_wr;
  assign arready = grant_rd;

  assign wr_resp = axi4_lite_decode_resp(64'(awaddr), awprot, MEM_ADDR_WIDTH, REQUIRE_PRIV);
  assign rd_resp = axi4_lite_decode_resp(64'(araddr), arprot, MEM_ADDR_WIDTH, REQUIRE_PRIV);

  // NOTE: every register here uses <= so all state updates see pre-edge values,
  // regardless of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_write_first <= 1'b0;
      mem_valid      <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wstrb      <= '0;
      bvalid         <= 1'b0;
      bresp          <= AXI4_LITE_OKAY;
      rvalid         <= 1'b0;
      rresp          <= AXI4_LITE_OKAY;
      rdata          <= '0;
    end else begin
      if (in_idle && wr_cand && rd_cand) rr_write_first <= !rr_write_first;

      unique case (state)
        IDLE: begin
          if (grant_rd) begin
            if (rd_resp == AXI4_LITE_OKAY) begin
              mem_valid <= 1'b1;
              mem_write <= 1'b0;
              mem_addr  <= araddr[MEM_ADDR_WIDTH+1:2];
              rresp     <= AXI4_LITE_OKAY;
              state     <= RD_ISSUE;
            end else begin
              rresp  <= rd_resp;
              rdata  <= '0;
              rvalid <= 1'b1;
              state  <= RD_RESP;
            end
          end else if (grant_wr) begin
            if (wr_resp == AXI4_LITE_OKAY) begin
              mem_valid <= 1'b1;
              mem_write <= 1'b1;
              mem_addr  <= awaddr[MEM_ADDR_WIDTH+1:2];
              mem_wdata <= wdata;
              mem_wstrb <= wstrb;
              state     <= WR_ISSUE;
            end else begin
              bresp  <= wr_resp;
              bvalid <= 1'b1;
              state  <= WR_RESP;
            end
          end
        end
        WR_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            bresp     <= AXI4_LITE_OKAY;
            bvalid    <= 1'b1;
            state     <= WR_RESP;
          end
        end
        RD_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        // Read data is only captured here; a stray mem_rvalid elsewhere is dropped.
        RD_WAIT: begin
          if (mem_rvalid) begin
            rdata  <= mem_rdata;
            rvalid <= 1'b1;
            state  <= RD_RESP;
          end
        end
        WR_RESP: begin
          if (bready) begin
            bvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rvalid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_lite_mem_bridge.md
# axi4_lite_mem_bridge

AXI4-Lite slave that terminates one AXI4-Lite port and drives a single-outstanding, word-addressed memory request port (register file, BRAM, peripheral block). It consumes the `axi4_lite` response and protection types, decodes the address window, enforces the privilege policy and serialises reads and writes through one FSM. It sits directly downstream of an AXI4-Lite master or interconnect.

## Interface
- `ADDR_WIDTH`, 32: AXI byte-address width.
- `DATA_WIDTH`, 32: data width; only 32 is legal.
- `MEM_ADDR_WIDTH`, 10: word-address width of the memory port; the window is 4·2^MEM_ADDR_WIDTH bytes from address 0.
- `REQUIRE_PRIV`, 0: when 1, unprivileged accesses are rejected with SLVERR.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous, active-low reset
- `awvalid`/`awready`  in/out  1  write-address handshake
- `awaddr`  in  ADDR_WIDTH  write byte address
- `awprot`  in  axi4_lite_prot_t  write protection
- `wvalid`/`wready`  in/out  1  write-data handshake
- `wdata`  in  32  write data
- `wstrb`  in  4  byte strobes
- `bvalid`/`bready`  out/in  1  write-response handshake
- `bresp`  out  axi4_lite_resp_t  write response
- `arvalid`/`arready`  in/out  1  read-address handshake
- `araddr`  in  ADDR_WIDTH  read byte address
- `arprot`  in  axi4_lite_prot_t  read protection
- `rvalid`/`rready`  out/in  1  read-data handshake
- `rdata`  out  32  read data
- `rresp`  out  axi4_lite_resp_t  read response
- `mem_valid`/`mem_ready`  out/in  1  memory request handshake
- `mem_write`  out  1  1 = write, 0 = read
- `mem_addr`  out  MEM_ADDR_WIDTH  word address, i.e. addr[MEM_ADDR_WIDTH+1:2]
- `mem_wdata`  out  32  write data
- `mem_wstrb`  out  4  write strobes
- `mem_rvalid`  in  1  read data valid; no backpressure
- `mem_rdata`  in  32  read data

## Operation
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, WR_RESP, RD_RESP.
- IDLE, write candidate: `awvalid && wvalid`. `awready` and `wready` assert together, for one cycle, only when both are valid. AW and W are never accepted separately.
- IDLE, read candidate: `arvalid`, accepted via `arready`.
- Both candidates in the same cycle: a round-robin bit decides. It is 0 (read wins) after reset and toggles after every arbitrated conflict.
- Decode on acceptance:
  - Any set bit in addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] gives DECERR.
  - Otherwise, `REQUIRE_PRIV` with prot.privilege == AXI4_LITE_UNPRIVILEDGED_ACCESS gives SLVERR.
  - Otherwise OKAY.
  - addr[1:0] is ignored.
- An errored access never reaches the memory port. IDLE goes directly to WR_RESP or RD_RESP; an errored read returns `rdata` = 0.
- Write path: WR_ISSUE holds `mem_valid`. On the `mem_ready` handshake it moves to WR_RESP with `bresp` OKAY.
- Read path: RD_ISSUE holds `mem_valid` and moves to RD_WAIT on handshake. In RD_WAIT, `mem_rvalid` captures `mem_rdata` into the `rdata` register and moves to RD_RESP.
- `mem_rvalid` outside RD_WAIT is ignored.
- WR_RESP holds `bvalid` until `bready`; RD_RESP holds `rvalid` until `rready`. Both then return to IDLE.
- Request outputs (`mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_write`) are registered at acceptance and stay stable while `mem_valid` is high.

## Timing
- Reset values:
  - All ready and valid outputs 0; FSM in IDLE.
  - `bresp`/`rresp` = OKAY; `rdata`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `mem_write` = 0.
  - Round-robin bit 0.
- Reset mid-transaction: the transaction is abandoned at the next edge with `rst_n` low, and no response is issued.
- Latency, write: AW/W accepted in cycle N, `mem_valid` in N+1; mem handshake in cycle M, `bvalid` in M+1.
- Latency, read: AR accepted in cycle N, `mem_valid` in N+1; `mem_rvalid` in cycle K, `rvalid` with data in K+1.
- Errored access: accepted in cycle N, response valid in N+1.
- Minimum round trip with zero-wait memory: 3 cycles for a write, 4 for a read.
- After the B or R handshake in cycle P, the FSM is in IDLE at P+1, and ready can assert in P+1 (no dead cycle beyond IDLE).
- Ready outputs are combinational from IDLE and the input valids. Every other output is registered.
- Only one transaction is ever outstanding.

## Structure
- Add `axi4_lite_mem_bridge_state_t` (the FSM enum) to package `axi4_lite`.
- Add a function `axi4_lite_decode_resp` to the same package: address plus prot plus parameters in, `axi4_lite_resp_t` out. Future AXI4-Lite slaves reuse it.
- No sub-module; the block is a single FSM with a datapath register set (~200 RTL lines).

## Test plan
- Write 0xDEADBEEF, `wstrb` 0xF, to 0x0000_0010 with `mem_ready` tied 1 → `mem_addr` = 4 and `mem_wdata` = 0xDEADBEEF in N+1; `bvalid`, `bresp` OKAY in N+2.
- Read 0x0000_0010 with `mem_rvalid` returned 2 cycles after the request handshake, carrying 0x12345678 → `rdata` = 0x12345678, `rresp` OKAY, one cycle after `mem_rvalid`.
- Read 0x0000_1000 (MEM_ADDR_WIDTH = 10) → DECERR, `rdata` 0, `rvalid` in N+1, `mem_valid` never asserts.
- `REQUIRE_PRIV` = 1, write with awprot.privilege = 0 → `bresp` SLVERR, no memory request. The same write with privilege = 1 → OKAY.
- Write and read presented simultaneously twice in a row → first conflict serves the read, second serves the write. `wvalid` alone with `awvalid` low → `wready` stays 0.
- `rready` held low 5 cycles → `rvalid` and `rdata` stay stable. `rst_n` low during RD_WAIT → all outputs return to reset values next cycle, and a later `mem_rvalid` is ignored.
